// File: rtl/store_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer_if
// Purpose  : Core load/store handshake plus data-memory port bundle for the
//            store buffer. The master side is the core together with the
//            data memory; the slave side is the buffer itself.
// Revision : 1.0 - initial release
// ============================================================================
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic          st_ready;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic [31:0]   ld_data;
  logic          ld_stall;
  logic          mem_we;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_din;
  logic [31:0]   mem_dout;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_dout,
    input  st_ready, ld_data, ld_stall, mem_we, mem_addr, mem_din, count, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_dout,
    output st_ready, ld_data, ld_stall, mem_we, mem_addr, mem_din, count, empty
  );
endinterface
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : Word-granular store FIFO in front of a single-port data memory.
//            Stores drain one per cycle when the core is not loading; loads
//            take priority and see the youngest buffered store to the same
//            word. A full buffer forces a drain and stalls the load.
// Config   : STORE_BUF_FWD_EN - when defined, loads are forwarded from the
//            buffer; when undefined, a load hitting a buffered word stalls
//            until that word has drained.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_full;
  logic          w_hit;
  logic [PW-1:0] w_idx;
  logic          w_stall;
  logic          w_drain;
  logic          w_push;
`ifdef STORE_BUF_FWD_EN
  logic [31:0]   w_fwd_data;
`endif

  assign w_full = (r_count == c_depth);

  // Scan valid entries oldest to youngest so the last match is the youngest
`ifdef STORE_BUF_FWD_EN
  always_comb begin
    w_hit      = 1'b0;
    w_fwd_data = '0;
    w_idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if ((CW'(k) < r_count) && (r_addr[w_idx] == bus.ld_addr[31:2])) begin
        w_hit      = 1'b1;
        w_fwd_data = r_data[w_idx];
      end
    end
  end
`else
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + PW'(k);
      if ((CW'(k) < r_count) && (r_addr[w_idx] == bus.ld_addr[31:2])) begin
        w_hit = 1'b1;
      end
    end
  end
`endif

  // A full buffer always stalls a load so the head can drain; without
  // forwarding a hit also stalls until the matching word reaches memory.
`ifdef STORE_BUF_FWD_EN
  assign w_stall = bus.ld_valid && w_full;
`else
  assign w_stall = bus.ld_valid && (w_full || w_hit);
`endif

  assign w_drain = (r_count != '0) && (!bus.ld_valid || w_stall);
  assign w_push  = bus.st_valid && bus.st_ready;

  assign bus.st_ready = !reset && !w_full;
  assign bus.ld_stall = w_stall;
  assign bus.mem_we   = w_drain;
  assign bus.mem_addr = w_drain ? {r_addr[r_head], 2'b00} : bus.ld_addr;
  assign bus.mem_din  = w_drain ? r_data[r_head] : 32'h0;
  assign bus.count    = r_count;
  assign bus.empty    = (r_count == '0);

`ifdef STORE_BUF_FWD_EN
  assign bus.ld_data = (bus.ld_valid && !w_stall) ? (w_hit ? w_fwd_data : bus.mem_dout) : 32'h0;
`else
  assign bus.ld_data = (bus.ld_valid && !w_stall) ? bus.mem_dout : 32'h0;
`endif

  // Head/tail pointers and occupancy; reset discards all pending stores
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + PW'(1);
      if (w_drain) r_head <= r_head + PW'(1);
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage is left uncleared; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.st_addr[31:2];
      r_data[r_tail] <= bus.st_data;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Self-checking bench for store_buffer: queue-based reference
//            model, per-cycle output comparison, directed scenarios and a
//            randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    logic        st_ready;
    logic        stall;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] ld_data;
    int          count;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic chk_en;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] tbmem [64];
  logic [31:0] mmem  [64];
  ent_t        q [$];

  store_buffer_if #(.DEPTH(DEPTH)) sb ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sb.slave)
  );

  always #5 clk = ~clk;

  assign sb.mem_dout = tbmem[sb.mem_addr[7:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: what the outputs must be given the queue contents and inputs
  function automatic exp_t model_eval();
    exp_t        e;
    logic        hit = 1'b0;
    logic [31:0] fwd = 32'h0;
    logic        full;
    for (int i = 0; i < q.size(); i++)
      if (q[i].waddr == sb.ld_addr[31:2]) begin
        hit = 1'b1;
        fwd = q[i].data;
      end
    full = (q.size() == DEPTH);
`ifdef STORE_BUF_FWD_EN
    e.stall = sb.ld_valid && full;
`else
    e.stall = sb.ld_valid && (full || hit);
`endif
    e.we   = (q.size() > 0) && (!sb.ld_valid || e.stall);
    e.addr = e.we ? {q[0].waddr, 2'b00} : sb.ld_addr;
    e.din  = e.we ? q[0].data : 32'h0;
    if (sb.ld_valid && !e.stall) begin
`ifdef STORE_BUF_FWD_EN
      e.ld_data = hit ? fwd : mmem[sb.ld_addr[7:2]];
`else
      e.ld_data = mmem[sb.ld_addr[7:2]];
`endif
    end else begin
      e.ld_data = 32'h0;
    end
    e.st_ready = !reset && !full;
    e.count    = q.size();
    return e;
  endfunction

  // Model state update on each clock edge; asynchronous reset empties it
  initial begin
    exp_t e;
    int   pre;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q.delete();
      end else begin
        e   = model_eval();
        pre = q.size();
        if (e.we) begin
          mmem[q[0].waddr[5:0]] = q[0].data;
          void'(q.pop_front());
        end
        if (sb.st_valid && pre < DEPTH)
          q.push_back({sb.st_addr[31:2], sb.st_data});
      end
    end
  end

  // Data memory seen by the DUT: synchronous write, combinational read
  initial begin
    forever begin
      @(posedge clk);
      if (sb.mem_we) tbmem[sb.mem_addr[7:2]] = sb.mem_din;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e = model_eval();
        chk("st_ready", 32'(sb.st_ready), 32'(e.st_ready));
        chk("ld_stall", 32'(sb.ld_stall), 32'(e.stall));
        chk("ld_data",  sb.ld_data, e.ld_data);
        chk("mem_we",   32'(sb.mem_we), 32'(e.we));
        chk("mem_addr", sb.mem_addr, e.addr);
        chk("mem_din",  sb.mem_din, e.din);
        chk("count",    32'(sb.count), 32'(e.count));
        chk("empty",    32'(sb.empty), 32'(e.count == 0));
      end
    end
  end

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    sb.st_valid = sv;
    sb.st_addr  = sa;
    sb.st_data  = sd;
    sb.ld_valid = lv;
    sb.ld_addr  = la;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    repeat (n) tick();
  endtask

  // Stimulus: directed scenarios with literal expectations, then random traffic
  initial begin
    for (int i = 0; i < 64; i++) begin
      tbmem[i] = 32'h0;
      mmem[i]  = 32'h0;
    end
    chk_en = 1'b0;
    reset  = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #12;
    chk("rst_count",    32'(sb.count), 32'd0);
    chk("rst_empty",    32'(sb.empty), 32'd1);
    chk("rst_st_ready", 32'(sb.st_ready), 32'd0);
    chk("rst_mem_we",   32'(sb.mem_we), 32'd0);
    chk("rst_ld_stall", 32'(sb.ld_stall), 32'd0);
    chk("rst_ld_data",  sb.ld_data, 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Single store drains the following cycle
    tick();
    drive(1'b1, 32'h10, 32'hAAAA0001, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    chk("s1_mem_we",   32'(sb.mem_we), 32'd1);
    chk("s1_mem_addr", sb.mem_addr, 32'h10);
    chk("s1_mem_din",  sb.mem_din, 32'hAAAA0001);
    tick();
    #2;
    chk("s1_count", 32'(sb.count), 32'd0);
    chk("s1_mem",   tbmem[4], 32'hAAAA0001);

    // Same-address stores, load of that word the cycle after the second
    drive(1'b1, 32'h20, 32'h1, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h20, 32'h2, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h22);
    #2;
`ifdef STORE_BUF_FWD_EN
    chk("s2_ld_data",  sb.ld_data, 32'h2);
    chk("s2_ld_stall", 32'(sb.ld_stall), 32'd0);
`else
    chk("s2_ld_stall", 32'(sb.ld_stall), 32'd1);
    chk("s2_mem_din",  sb.mem_din, 32'h2);
`endif
    tick();
    idle(3);
    chk("s2_mem_order", tbmem[8], 32'h2);

    // Fill under a held unrelated load, then forced drain
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h50 + 32'(4 * i), 32'h500 + 32'(i), 1'b1, 32'h40);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h40);
    #2;
    chk("s3_count",    32'(sb.count), 32'd4);
    chk("s3_st_ready", 32'(sb.st_ready), 32'd0);
    chk("s3_ld_stall", 32'(sb.ld_stall), 32'd1);
    chk("s3_mem_we",   32'(sb.mem_we), 32'd1);
    chk("s3_mem_addr", sb.mem_addr, 32'h50);
    tick();
    #2;
    chk("s3_st_ready_back", 32'(sb.st_ready), 32'd1);
    chk("s3_count_after",   32'(sb.count), 32'd3);
    idle(5);

    // Load of a buffered word
    drive(1'b1, 32'h30, 32'h5, 1'b1, 32'h40);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h30);
    #2;
`ifdef STORE_BUF_FWD_EN
    chk("s4_ld_stall", 32'(sb.ld_stall), 32'd0);
    chk("s4_ld_data",  sb.ld_data, 32'h5);
`else
    chk("s4_ld_stall", 32'(sb.ld_stall), 32'd1);
    chk("s4_mem_we",   32'(sb.mem_we), 32'd1);
    chk("s4_mem_din",  sb.mem_din, 32'h5);
`endif
    tick();
    #2;
    chk("s4_ld_stall2", 32'(sb.ld_stall), 32'd0);
    chk("s4_ld_data2",  sb.ld_data, 32'h5);
    idle(3);

    // Asynchronous reset with three pending stores
    drive(1'b1, 32'h80, 32'h801, 1'b1, 32'h44);
    tick();
    drive(1'b1, 32'h84, 32'h802, 1'b1, 32'h44);
    tick();
    drive(1'b1, 32'h88, 32'h803, 1'b1, 32'h44);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h44);
    #2;
    chk("s5_count_pre", 32'(sb.count), 32'd3);
    reset = 1'b1;
    #1;
    chk("s5_count",  32'(sb.count), 32'd0);
    chk("s5_empty",  32'(sb.empty), 32'd1);
    chk("s5_mem_we", 32'(sb.mem_we), 32'd0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    idle(4);
    chk("s5_no_write0", tbmem[32], 32'h0);
    chk("s5_no_write1", tbmem[33], 32'h0);
    chk("s5_no_write2", tbmem[34], 32'h0);

    // Nine store/drain pairs wrap the pointers
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'hA0 + 32'(4 * (i % 6)), 32'h600 + 32'(i), 1'b0, 32'h0);
      tick();
      idle(1);
    end
    idle(2);
    for (int j = 0; j < 6; j++)
      chk("s6_wrap_mem", tbmem[40 + j], 32'h600 + 32'((j < 3) ? j + 6 : j));

    // Random traffic over a small set of words for frequent hits
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 9) < 6), 32'($urandom_range(0, 63)), $urandom(),
            ($urandom_range(0, 9) < 5), 32'($urandom_range(0, 63)));
      tick();
    end
    idle(8);
    chk_en = 1'b0;
    for (int i = 0; i < 64; i++)
      chk("final_mem", tbmem[i], mmem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
